// File: rtl/axi_rom_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_rom_responder
// Function : AXI read-only memory responder; INCR reads fetched one word per
//            beat from a synchronous ROM port, all writes answered SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rom_responder #(
    parameter int unsigned IdWidth  = 4,
    parameter logic [63:0] BaseAddr = 64'h0001_0000,
    parameter int unsigned MemWords = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        ar_valid_i,
    output logic                        ar_ready_o,
    input  logic [IdWidth-1:0]          ar_id_i,
    input  logic [63:0]                 ar_addr_i,
    input  logic [7:0]                  ar_len_i,
    input  logic [2:0]                  ar_size_i,
    input  logic [1:0]                  ar_burst_i,
    output logic                        r_valid_o,
    input  logic                        r_ready_i,
    output logic [IdWidth-1:0]          r_id_o,
    output logic [63:0]                 r_data_o,
    output logic [1:0]                  r_resp_o,
    output logic                        r_last_o,
    input  logic                        aw_valid_i,
    output logic                        aw_ready_o,
    input  logic [IdWidth-1:0]          aw_id_i,
    input  logic                        w_valid_i,
    output logic                        w_ready_o,
    input  logic                        w_last_i,
    output logic                        b_valid_o,
    input  logic                        b_ready_i,
    output logic [IdWidth-1:0]          b_id_o,
    output logic [1:0]                  b_resp_o,
    output logic                        mem_req_o,
    output logic [$clog2(MemWords)-1:0] mem_addr_o,
    input  logic [63:0]                 mem_rdata_i
);

    localparam int unsigned c_MEM_AW = $clog2(MemWords);
    localparam logic [1:0]  c_OKAY   = 2'b00;
    localparam logic [1:0]  c_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        BEAT  = 2'd2,
        ERR   = 2'd3
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    rd_state_e            rd_state_q, rd_state_d;
    logic [IdWidth-1:0]   rd_id_q, rd_id_d;
    logic [63:0]          rd_addr_q, rd_addr_d;
    logic [7:0]           rd_len_q, rd_len_d;
    logic [7:0]           rd_beat_q, rd_beat_d;

    wr_state_e            wr_state_q, wr_state_d;
    logic [IdWidth-1:0]   wr_id_q, wr_id_d;

    // 65-bit arithmetic so a burst running past 2^64 cannot wrap into range
    logic [64:0] w_ar_end;
    logic [64:0] w_mem_end;
    logic        w_ar_legal;

    assign w_ar_end   = {1'b0, ar_addr_i} + (({57'd0, ar_len_i} + 65'd1) * 65'd8);
    assign w_mem_end  = {1'b0, BaseAddr} + (65'(MemWords) * 65'd8);
    assign w_ar_legal = (ar_burst_i == 2'b01) && (ar_size_i == 3'd3) &&
                        (ar_addr_i[2:0] == 3'd0) && (ar_addr_i >= BaseAddr) &&
                        (w_ar_end <= w_mem_end);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state_q <= IDLE;
            rd_id_q    <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_beat_q  <= '0;
            wr_state_q <= W_IDLE;
            wr_id_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_id_q    <= rd_id_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
            rd_beat_q  <= rd_beat_d;
            wr_state_q <= wr_state_d;
            wr_id_q    <= wr_id_d;
        end
    end

    assign r_id_o     = rd_id_q;
    assign b_id_o     = wr_id_q;
    assign mem_addr_o = c_MEM_AW'((rd_addr_q - BaseAddr) >> 3);

    // Read channel; every output is held low while reset is asserted
    always_comb begin
        rd_state_d = rd_state_q;
        rd_id_d    = rd_id_q;
        rd_addr_d  = rd_addr_q;
        rd_len_d   = rd_len_q;
        rd_beat_d  = rd_beat_q;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        r_data_o   = '0;
        r_resp_o   = c_OKAY;
        r_last_o   = 1'b0;
        mem_req_o  = 1'b0;
        if (!rst_i) begin
            case (rd_state_q)
                IDLE: begin
                    ar_ready_o = 1'b1;
                    if (ar_valid_i) begin
                        rd_id_d    = ar_id_i;
                        rd_addr_d  = ar_addr_i;
                        rd_len_d   = ar_len_i;
                        rd_beat_d  = '0;
                        rd_state_d = w_ar_legal ? FETCH : ERR;
                    end
                end
                FETCH: begin
                    mem_req_o  = 1'b1;
                    rd_state_d = BEAT;
                end
                BEAT: begin
                    r_valid_o = 1'b1;
                    r_data_o  = mem_rdata_i;
                    r_last_o  = (rd_beat_q == rd_len_q);
                    if (r_ready_i) begin
                        if (rd_beat_q == rd_len_q) begin
                            rd_state_d = IDLE;
                        end else begin
                            rd_addr_d  = rd_addr_q + 64'd8;
                            rd_beat_d  = rd_beat_q + 8'd1;
                            rd_state_d = FETCH;
                        end
                    end
                end
                ERR: begin
                    r_valid_o = 1'b1;
                    r_resp_o  = c_SLVERR;
                    r_last_o  = (rd_beat_q == rd_len_q);
                    if (r_ready_i) begin
                        if (rd_beat_q == rd_len_q) begin
                            rd_state_d = IDLE;
                        end else begin
                            rd_beat_d = rd_beat_q + 8'd1;
                        end
                    end
                end
                default: rd_state_d = IDLE;
            endcase
        end
    end

    // Write channel: data is swallowed, response is always SLVERR
    always_comb begin
        wr_state_d = wr_state_q;
        wr_id_d    = wr_id_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        b_resp_o   = c_OKAY;
        if (!rst_i) begin
            case (wr_state_q)
                W_IDLE: begin
                    aw_ready_o = 1'b1;
                    if (aw_valid_i) begin
                        wr_id_d    = aw_id_i;
                        wr_state_d = W_DATA;
                    end
                end
                W_DATA: begin
                    w_ready_o = 1'b1;
                    if (w_valid_i && w_last_i) begin
                        wr_state_d = W_RESP;
                    end
                end
                W_RESP: begin
                    b_valid_o = 1'b1;
                    b_resp_o  = c_SLVERR;
                    if (b_ready_i) begin
                        wr_state_d = W_IDLE;
                    end
                end
                default: wr_state_d = W_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
